// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR random source.
// Provides the Fibonacci tap-mask table (widths 4..16), the sampler state
// enum, a width-legality check and the single-step feedback function.
package lfsr_pkg;

  localparam int unsigned MIN_WIDTH = 4;
  localparam int unsigned MAX_WIDTH = 16;
  localparam int unsigned CNT_W     = 8;   // holds SHIFTS-1 for SHIFTS up to 255

  typedef enum logic {
    GATHER = 1'b0,
    HOLD   = 1'b1
  } sampler_state_e;

  // True when an LFSR length is supported by the tap table.
  function automatic bit width_legal(input int unsigned w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
  endfunction

  // Maximal-length tap masks; bit i set means stage i feeds the XOR.
  function automatic logic [15:0] tap_mask(input int unsigned w);
    logic [15:0] m;
    m = 16'h0000;
    case (w)
      4:       m = 16'h000C;  // x^4+x^3
      5:       m = 16'h0014;  // x^5+x^3
      6:       m = 16'h0030;  // x^6+x^5
      7:       m = 16'h0060;  // x^7+x^6
      8:       m = 16'h00B8;  // x^8+x^6+x^5+x^4
      9:       m = 16'h0110;  // x^9+x^5
      10:      m = 16'h0240;  // x^10+x^7
      11:      m = 16'h0500;  // x^11+x^9
      12:      m = 16'h0829;  // x^12+x^6+x^4+x^1
      13:      m = 16'h100D;  // x^13+x^4+x^3+x^1
      14:      m = 16'h2015;  // x^14+x^5+x^3+x^1
      15:      m = 16'h6000;  // x^15+x^14
      16:      m = 16'hD008;  // x^16+x^15+x^13+x^4
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

  // One left-shift step of a w-bit Fibonacci LFSR held in the low w bits.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s, input int unsigned w);
    logic [15:0] keep;
    keep = (16'h0001 << w) - 16'h0001;
    return {s[14:0], ^(s & tap_mask(w))} & keep;
  endfunction

endpackage

// File: rtl/lfsr_random_source_core.sv
// LFSR register with feedback, reseed and all-zero lockup guard.
// Ports: clk, reset_n (async active-low), step (advance one position),
//        load/load_value (reseed; zero maps to SEED), state (current value).
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned SEED  = 13
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] state
);

  localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;

  // Reseed wins, then the zero-state escape (regardless of step), then stepping.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (load_value == '0) ? SEED_V : load_value;
    end else if (lfsr_q == '0) begin
      lfsr_d = SEED_V;
    end else if (step) begin
      lfsr_d = WIDTH'(lfsr_next(16'(lfsr_q), WIDTH));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= SEED_V;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/lfsr_random_source.sv
// Random value source: an LFSR is stepped SHIFTS times per sample, the low
// OUT_BITS of the next state are taken, values >= RANGE are discarded
// (rejected pulse) and accepted values are offered on a valid/ready port.
// Ports: clk, reset_n (async active-low), en (step enable), seed_load /
//        seed_value (reseed), rnd / rnd_valid / rnd_ready (output handshake),
//        rejected (one-cycle discard pulse).
module lfsr_random_source
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned OUT_BITS = 3,
  parameter int unsigned SHIFTS   = 10,
  parameter int unsigned SEED     = 13,
  parameter int unsigned RANGE    = 2 ** OUT_BITS
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic                seed_load,
  input  logic [WIDTH-1:0]    seed_value,
  output logic [OUT_BITS-1:0] rnd,
  output logic                rnd_valid,
  input  logic                rnd_ready,
  output logic                rejected
);

  // Elaboration-time parameter legality.
  if (!width_legal(WIDTH)) begin : g_bad_width
    $error("lfsr_random_source: WIDTH must be 4..16");
  end
  if ((OUT_BITS < 1) || (OUT_BITS > WIDTH)) begin : g_bad_out_bits
    $error("lfsr_random_source: OUT_BITS must be 1..WIDTH");
  end
  if ((SHIFTS < 1) || (SHIFTS > 255)) begin : g_bad_shifts
    $error("lfsr_random_source: SHIFTS must be 1..255");
  end
  if ((SEED == 0) || (SEED >= (2 ** WIDTH))) begin : g_bad_seed
    $error("lfsr_random_source: SEED must be nonzero and below 2**WIDTH");
  end
  if ((RANGE < 1) || (RANGE > (2 ** OUT_BITS))) begin : g_bad_range
    $error("lfsr_random_source: RANGE must be 1..2**OUT_BITS");
  end

  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SHIFTS - 1);
  localparam logic [OUT_BITS:0] RANGE_V  = (OUT_BITS + 1)'(RANGE);

  logic [WIDTH-1:0]    lfsr_state;
  logic [OUT_BITS-1:0] sample;
  logic                sample_ok;

  sampler_state_e      state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [OUT_BITS-1:0] rnd_q, rnd_d;
  logic                rnd_valid_q, rnd_valid_d;
  logic                rejected_q, rejected_d;

  lfsr_core #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_core (
    .clk        (clk),
    .reset_n    (reset_n),
    .step       (en),
    .load       (seed_load),
    .load_value (seed_value),
    .state      (lfsr_state)
  );

  // Sample is taken from the state the LFSR moves to on this edge.
  assign sample    = OUT_BITS'(lfsr_next(16'(lfsr_state), WIDTH));
  assign sample_ok = {1'b0, sample} < RANGE_V;

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rnd_d       = rnd_q;
    rnd_valid_d = rnd_valid_q;
    rejected_d  = 1'b0;
    if (seed_load) begin
      state_d     = GATHER;
      count_d     = '0;
      rnd_valid_d = 1'b0;
    end else begin
      case (state_q)
        GATHER: begin
          if (en) begin
            if (count_q == LAST_CNT) begin
              count_d = '0;
              if (sample_ok) begin
                rnd_d       = sample;
                rnd_valid_d = 1'b1;
                state_d     = HOLD;
              end else begin
                rejected_d = 1'b1;
              end
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (rnd_ready) begin
            rnd_valid_d = 1'b0;
            count_d     = '0;
            state_d     = GATHER;
          end
        end
        default: begin
          state_d     = GATHER;
          count_d     = '0;
          rnd_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= GATHER;
      count_q     <= '0;
      rnd_q       <= '0;
      rnd_valid_q <= 1'b0;
      rejected_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rnd_q       <= rnd_d;
      rnd_valid_q <= rnd_valid_d;
      rejected_q  <= rejected_d;
    end
  end

  assign rnd       = rnd_q;
  assign rnd_valid = rnd_valid_q;
  assign rejected  = rejected_q;

endmodule

// File: tb/tb_lfsr_random_source.sv
// Bench for lfsr_random_source: two instances (full range and RANGE=5) share
// stimulus; a transaction-level model predicts delivered/rejected samples
// into queues and a negedge monitor pops and compares them.
module tb_lfsr_random_source;

  localparam int SEED   = 13;
  localparam int SHIFTS = 10;

  typedef struct {
    bit is_rej;
    int val;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic       seed_load;
  logic [9:0] seed_value;
  logic       rnd_ready;

  logic [2:0] rnd0, rnd1;
  logic       rnd_valid0, rnd_valid1;
  logic       rejected0, rejected1;

  exp_t q0[$];
  exp_t q1[$];
  int   cur[2];
  int   gathered[2];
  bit   holding[2];
  int   rng[2] = '{8, 5};

  int total = 0;
  int bad = 0;
  int delivered = 0;

  always #5 clk = ~clk;

  lfsr_random_source u_dut0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .seed_load  (seed_load),
    .seed_value (seed_value),
    .rnd        (rnd0),
    .rnd_valid  (rnd_valid0),
    .rnd_ready  (rnd_ready),
    .rejected   (rejected0)
  );

  lfsr_random_source #(.RANGE(5)) u_dut1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .seed_load  (seed_load),
    .seed_value (seed_value),
    .rnd        (rnd1),
    .rnd_valid  (rnd_valid1),
    .rnd_ready  (rnd_ready),
    .rejected   (rejected1)
  );

  // x^10 + x^7 polynomial, stages 9 and 6, computed arithmetically.
  function automatic int lfsr_step(input int v);
    int fb;
    fb = ((v >> 9) ^ (v >> 6)) & 1;
    return ((v * 2) % 1024) + fb;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int i, input bit rej, input int v);
    exp_t e;
    e.is_rej = rej;
    e.val    = v;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic drop_pending(input int i);
    if (i == 0) begin
      if (q0.size() > 0) void'(q0.pop_back());
    end else begin
      if (q1.size() > 0) void'(q1.pop_back());
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      if (holding[i]) drop_pending(i);
      cur[i]      = SEED;
      gathered[i] = 0;
      holding[i]  = 1'b0;
    end
  endtask

  // Predicts what the coming clock edge does, from the current inputs.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (seed_load) begin
        if (holding[i]) drop_pending(i);
        cur[i]      = (seed_value == 10'd0) ? SEED : int'(seed_value);
        gathered[i] = 0;
        holding[i]  = 1'b0;
      end else begin
        bit hs;
        hs = holding[i] && rnd_ready;
        if (cur[i] == 0) begin
          cur[i] = SEED;
        end else if (en) begin
          cur[i] = lfsr_step(cur[i]);
          if (!holding[i]) begin
            gathered[i]++;
            if (gathered[i] == SHIFTS) begin
              gathered[i] = 0;
              if ((cur[i] % 8) < rng[i]) begin
                push_exp(i, 1'b0, cur[i] % 8);
                holding[i] = 1'b1;
              end else begin
                push_exp(i, 1'b1, 0);
              end
            end
          end
        end
        if (hs) begin
          holding[i]  = 1'b0;
          gathered[i] = 0;
        end
      end
    end
  endtask

  task automatic drive_cycle(input bit e, input bit l, input logic [9:0] sv, input bit r);
    en         = e;
    seed_load  = l;
    seed_value = sv;
    rnd_ready  = r;
    if (reset_n) model_edge();
    @(posedge clk);
    #2;
  endtask

  // Compares one observed delivery or rejection against the queue head.
  task automatic mon(input int i, input bit hs, input bit rej, input logic [2:0] r);
    exp_t e;
    bit   have;
    if (!hs && !rej) return;
    have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (!have) begin
      check($sformatf("dut%0d unexpected output", i), rej ? -1 : int'(r), -99);
    end else begin
      if (i == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      check($sformatf("dut%0d sample", i), rej ? -1 : int'(r), e.is_rej ? -1 : e.val);
      if (hs) delivered++;
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      mon(0, rnd_valid0 && rnd_ready && !seed_load, rejected0, rnd0);
      mon(1, rnd_valid1 && rnd_ready && !seed_load, rejected1, rnd1);
    end
  end

  initial begin
    int v;
    int last_hi;
    int pulses;
    bit hold_ok;

    reset_n    = 1'b0;
    en         = 1'b0;
    seed_load  = 1'b0;
    seed_value = '0;
    rnd_ready  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("reset rnd_valid", rnd_valid0, 0);
    check("reset rnd", rnd0, 0);
    check("reset rejected", rejected0, 0);
    check("reset rnd_valid dut1", rnd_valid1, 0);
    check("reset lfsr", u_dut0.u_core.state, SEED);
    reset_n = 1'b1;

    // First capture with the consumer stalled.
    for (int k = 1; k <= 10; k++) begin
      drive_cycle(1'b1, 1'b0, 10'd0, 1'b0);
      if (k == 9) check("valid before 10th step", rnd_valid0, 0);
    end
    check("first rnd", rnd0, 5);
    check("first rnd_valid", rnd_valid0, 1);
    check("dut1 reject pulse", rejected1, 1);
    check("dut1 no valid on reject", rnd_valid1, 0);
    drive_cycle(1'b1, 1'b0, 10'd0, 1'b0);
    check("reject pulse width", rejected1, 0);
    hold_ok = 1'b1;
    for (int k = 0; k < 19; k++) begin
      drive_cycle(1'b1, 1'b0, 10'd0, 1'b0);
      if (!(rnd_valid0 && rnd0 == 3'd5)) hold_ok = 1'b0;
    end
    check("value held while stalled", hold_ok, 1);
    v = SEED;
    repeat (20) v = lfsr_step(v);
    check("dut1 capture after reject", rnd1, v % 8);
    check("dut1 valid after reject", rnd_valid1, 1);

    // Reseed with zero during HOLD while ready is high.
    drive_cycle(1'b1, 1'b1, 10'd0, 1'b1);
    check("reseed clears valid", rnd_valid0, 0);
    check("reseed clears valid dut1", rnd_valid1, 0);
    check("reseed zero -> SEED", u_dut0.u_core.state, SEED);
    for (int k = 0; k < 10; k++) drive_cycle(1'b1, 1'b0, 10'd0, 1'b0);
    check("rnd after reseed", rnd0, 5);
    check("valid after reseed", rnd_valid0, 1);

    // Continuous ready: one-cycle pulses spaced 11 cycles apart.
    last_hi = -1;
    pulses  = 0;
    for (int k = 1; k <= 45; k++) begin
      drive_cycle(1'b1, 1'b0, 10'd0, 1'b1);
      if (rnd_valid0) begin
        pulses++;
        if (last_hi < 0) check("first pulse position", k, 11);
        else             check("pulse spacing", k - last_hi, 11);
        last_hi = k;
      end
    end
    check("pulse count", pulses, 4);

    // Enable toggling every cycle: ten enabled edges over twenty clocks.
    drive_cycle(1'b0, 1'b1, 10'd0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      drive_cycle(k[0], 1'b0, 10'd0, 1'b0);
      if (k == 18) check("no capture before 10th enabled edge", rnd_valid0, 0);
    end
    check("toggled-en rnd", rnd0, 5);
    check("toggled-en valid", rnd_valid0, 1);
    check("toggled-en dut1 reject", rejected1, 1);

    // Lockup guard: an all-zero state is replaced by SEED on the next edge.
    force u_dut0.u_core.lfsr_q = '0;
    #1;
    release u_dut0.u_core.lfsr_q;
    cur[0] = 0;
    drive_cycle(1'b0, 1'b0, 10'd0, 1'b0);
    check("lockup guard", u_dut0.u_core.state, SEED);
    check("lockup keeps held value", rnd_valid0, 1);

    // Asynchronous reset mid-HOLD clears outputs before any clock edge.
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async reset valid", rnd_valid0, 0);
    check("async reset rnd", rnd0, 0);
    check("async reset valid dut1", rnd_valid1, 0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    // Randomised traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      bit         e, l, r;
      logic [9:0] sv;
      e  = ($urandom_range(0, 3) != 0);
      l  = ($urandom_range(0, 63) == 0);
      sv = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom);
      r  = $urandom_range(0, 1) != 0;
      drive_cycle(e, l, sv, r);
    end
    @(negedge clk);
    #1;
    check("final valid dut0", rnd_valid0, int'(holding[0]));
    check("final valid dut1", rnd_valid1, int'(holding[1]));
    check("leftover dut0", q0.size(), holding[0] ? 1 : 0);
    check("leftover dut1", q1.size(), holding[1] ? 1 : 0);
    check("enough deliveries", int'(delivered > 100), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
